// File: rtl/arb16_ctrl.sv
// arb16_ctrl: 16-requester round-robin arbiter driving the select of a
// downstream 16:1 mux. Each requester holds its grant until it signals done.
// The released requester gets lowest priority in the next arbitration.
//
// Optional build macro: ARB16_TIMEOUT_EN
//   Defined:   a grant held HOLD_MAX cycles without done is force-released,
//              and timeout pulses for one cycle alongside the new grant/IDLE.
//   Undefined: grants are held indefinitely and timeout is tied low.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant active; arbitrate as soon as any request appears
// BUSY  | grant s16 active; wait for done (or forced release)

module arb16_ctrl #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  s16,
  output logic [15:0] gnt,
  output logic        valid,
  output logic        timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Last hold count before the limit. The counter saturates here, so it
  // never wraps even in builds without forced release.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [3:0]  s16_n;
  logic [15:0] gnt_n;
  logic        valid_n;
  logic        timeout_n;
  logic [7:0]  hold_cnt, hold_n;

  logic [3:0]  base;
  logic [3:0]  win;
  logic        win_found;
  logic        hold_at_lim;
  logic        force_rel;
  logic        release_now;

  // Circular priority scan starting at base and wrapping mod 16.
  function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] b);
    logic       found;
    logic [3:0] idx;
    logic [3:0] pick;
    found = 1'b0;
    pick  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = b + 4'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  assign hold_at_lim = (hold_cnt == HOLD_LAST);

`ifdef ARB16_TIMEOUT_EN
  // A simultaneous done wins: that release is reported as normal.
  assign force_rel = (state == BUSY) && !done && hold_at_lim;
`else
  assign force_rel = 1'b0;
`endif

  assign release_now = (state == BUSY) && (done || force_rel);

  // On release the scan starts just past the outgoing grant, so a requester
  // that is still asking ends up last in line.
  assign base = (state == BUSY) ? (s16 + 4'd1) : ptr;
  assign {win_found, win} = rr_pick(req, base);

  // Next-state and next-output logic. All outputs are registered.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    s16_n     = s16;
    gnt_n     = gnt;
    valid_n   = valid;
    timeout_n = 1'b0;
    hold_n    = hold_cnt;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = BUSY;
          s16_n   = win;
          gnt_n   = 16'(1) << win;
          valid_n = 1'b1;
          hold_n  = 8'd0;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_n     = s16 + 4'd1;
          timeout_n = force_rel;
          if (win_found) begin
            s16_n  = win;
            gnt_n  = 16'(1) << win;
            hold_n = 8'd0;
          end else begin
            state_n = IDLE;
            gnt_n   = 16'd0;
            valid_n = 1'b0;
          end
        end else if (!hold_at_lim) begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 16'd0;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      s16      <= 4'd0;
      gnt      <= 16'd0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      s16      <= s16_n;
      gnt      <= gnt_n;
      valid    <= valid_n;
      timeout  <= timeout_n;
      hold_cnt <= hold_n;
    end
  end

endmodule

// File: tb/tb_arb16_ctrl.sv
// Directed bench for arb16_ctrl. Each step drives req/done/rst, queues the
// expected registered outputs, and compares them one cycle later.
// Compile with ARB16_TIMEOUT_EN defined to exercise forced release.

module tb_arb16_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  s16;
  logic [15:0] gnt;
  logic        valid;
  logic        timeout;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [3:0]  s16;
    logic [15:0] gnt;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];

`ifdef ARB16_TIMEOUT_EN
  arb16_ctrl #(.HOLD_MAX(4)) dut (
`else
  arb16_ctrl dut (
`endif
    .clk(clk), .rst(rst), .req(req), .done(done),
    .s16(s16), .gnt(gnt), .valid(valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=sequence still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
  endtask

  // One clock: drive inputs, queue expectation, sample #1 after the edge.
  task automatic step(input string tag, input logic r, input logic [15:0] rq, input logic d,
                      input logic ev, input logic [3:0] es, input logic [15:0] eg,
                      input logic et);
    exp_t e;
    exp_t got;
    rst  = r;
    req  = rq;
    done = d;
    e.tag = tag; e.valid = ev; e.s16 = es; e.gnt = eg; e.timeout = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({got.tag, ".valid"},   16'(valid),   16'(got.valid));
    check({got.tag, ".s16"},     16'(s16),     16'(got.s16));
    check({got.tag, ".gnt"},     gnt,          got.gnt);
    check({got.tag, ".timeout"}, 16'(timeout), 16'(got.timeout));
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req = 16'h0; done = 1'b0;
    @(posedge clk); #1;

    // Reset state, single request, release to idle
    do_reset("rst0");
    step("idle_noreq", 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
    step("grant0",     1'b0, 16'h0001, 1'b0, 1'b1, 4'd0, 16'h0001, 1'b0);
    step("rel_idle",   1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
    step("idle_hold",  1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);

    // Full request vector, done every cycle: round-robin 0..15,0,1
    do_reset("rst1");
    step("rr_first", 1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd0, 16'h0001, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      logic [3:0] e_s;
      e_s = 4'(i % 16);
      step("rr_seq", 1'b0, 16'hFFFF, 1'b1, 1'b1, e_s, 16'(1) << e_s, 1'b0);
    end
    step("rr_idle", 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 16'h0000, 1'b0);
    // Pointer is now 2: requesters 1 and 3 -> 3 wins
    step("ptr_cont", 1'b0, 16'h000A, 1'b0, 1'b1, 4'd3, 16'h0008, 1'b0);

    // Wrap: release 14 with req=0x0005 -> 0, then 2
    do_reset("rst2");
    step("g14",      1'b0, 16'h4000, 1'b0, 1'b1, 4'd14, 16'h4000, 1'b0);
    step("wrap0",    1'b0, 16'h0005, 1'b1, 1'b1, 4'd0,  16'h0001, 1'b0);
    step("wrap2",    1'b0, 16'h0005, 1'b1, 1'b1, 4'd2,  16'h0004, 1'b0);
    step("wrap_idl", 1'b0, 16'h0000, 1'b1, 1'b0, 4'd2,  16'h0000, 1'b0);

    // Back-to-back handover 1 -> 7, grant held against req changes
    do_reset("rst3");
    step("g1",       1'b0, 16'h0082, 1'b0, 1'b1, 4'd1, 16'h0002, 1'b0);
    step("hand7",    1'b0, 16'h0082, 1'b1, 1'b1, 4'd7, 16'h0080, 1'b0);
    step("hold_req", 1'b0, 16'h0000, 1'b0, 1'b1, 4'd7, 16'h0080, 1'b0);
    step("hold_oth", 1'b0, 16'h0100, 1'b0, 1'b1, 4'd7, 16'h0080, 1'b0);
    step("rel8",     1'b0, 16'h0100, 1'b1, 1'b1, 4'd8, 16'h0100, 1'b0);
    // Sole requester re-granted back-to-back
    step("regrant8", 1'b0, 16'h0100, 1'b1, 1'b1, 4'd8, 16'h0100, 1'b0);
    step("rel_idl8", 1'b0, 16'h0000, 1'b1, 1'b0, 4'd8, 16'h0000, 1'b0);

    // Reset mid-grant abandons the grant without advancing the pointer
    do_reset("rst4");
    step("g9",       1'b0, 16'h0200, 1'b0, 1'b1, 4'd9, 16'h0200, 1'b0);
    step("rst_mid",  1'b1, 16'h0300, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
    step("post_rst", 1'b0, 16'h0300, 1'b0, 1'b1, 4'd8, 16'h0100, 1'b0);

    // Long hold without done
    do_reset("rst5");
    step("th_g0", 1'b0, 16'h0011, 1'b0, 1'b1, 4'd0, 16'h0001, 1'b0);
`ifdef ARB16_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      step("th_hold0", 1'b0, 16'h0011, 1'b0, 1'b1, 4'd0, 16'h0001, 1'b0);
    step("to_g4", 1'b0, 16'h0011, 1'b0, 1'b1, 4'd4, 16'h0010, 1'b1);
    for (int i = 0; i < 3; i++)
      step("th_hold4", 1'b0, 16'h0011, 1'b0, 1'b1, 4'd4, 16'h0010, 1'b0);
    // done coincides with the timeout condition: normal release, no pulse
    step("done_vs_to", 1'b0, 16'h0011, 1'b1, 1'b1, 4'd0, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++)
      step("th_hold0b", 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 16'h0001, 1'b0);
    step("to_idle", 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    step("to_clr",  1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
`else
    for (int i = 0; i < 22; i++)
      step("no_to_hold", 1'b0, 16'h0011, 1'b0, 1'b1, 4'd0, 16'h0001, 1'b0);
    step("no_to_rel", 1'b0, 16'h0011, 1'b1, 1'b1, 4'd4, 16'h0010, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
